// File: rtl/writeback_unit.sv
// RV32I writeback: load extraction, registered 1-cycle regfile write pulse; WB_BYPASS_EN adds operand bypass.
// ALU result written 1 cycle after accept, loads 1 cycle after mem_rvalid; in_ready low while a load waits.
module writeback_unit #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
`ifdef WB_BYPASS_EN
  input  logic [4:0]  rs1_addr,
  input  logic [4:0]  rs2_addr,
  input  logic [31:0] rs1_file_data,
  input  logic [31:0] rs2_file_data,
  output logic [31:0] rs1_data,
  output logic [31:0] rs2_data,
`endif
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_rd_addr,
  input  logic        in_reg_write,
  input  logic [31:0] in_result,
  input  logic        in_is_load,
  input  logic [2:0]  in_funct3,
  input  logic [1:0]  in_addr_lo,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rvalid,
  output logic [4:0]  rd_addr,
  output logic [31:0] rd_data,
  output logic        reg_write_enable,
  output logic [1:0]  err_code,
  input  logic        err_clear
);

  localparam logic [7:0] TIMEOUT_CNT = 8'(MEM_TIMEOUT);

  typedef enum logic {IDLE, WAIT_MEM} state_t;

  state_t      state, state_nxt;
  logic [7:0]  cnt, cnt_nxt;
  logic [4:0]  ld_rd;
  logic [2:0]  ld_f3;
  logic [1:0]  ld_lo;
  logic        ld_we;
  logic        latch_ld;
  logic [4:0]  rd_addr_nxt;
  logic [31:0] rd_data_nxt;
  logic        we_nxt;
  logic [1:0]  err_new;

  function automatic logic load_bad(input logic [2:0] f3, input logic [1:0] lo);
    case (f3)
      3'b001, 3'b101: load_bad = (lo == 2'd3);
      3'b010:         load_bad = (lo != 2'd0);
      3'b011, 3'b110, 3'b111: load_bad = 1'b1;
      default:        load_bad = 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] extract(input logic [2:0] f3, input logic [1:0] lo,
                                          input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{lo, 3'b000} +: 8];
    h = lo[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  extract = {{24{b[7]}}, b};
      3'b100:  extract = {24'd0, b};
      3'b001:  extract = {{16{h[15]}}, h};
      3'b101:  extract = {16'd0, h};
      default: extract = w;
    endcase
  endfunction

  assign in_ready = (state == IDLE);

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    rd_addr_nxt = rd_addr;
    rd_data_nxt = rd_data;
    we_nxt      = 1'b0;
    err_new     = 2'b00;
    latch_ld    = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          if (!in_is_load) begin
            rd_addr_nxt = in_rd_addr;
            rd_data_nxt = in_result;
            we_nxt      = in_reg_write & (|in_rd_addr);
          end else if (load_bad(in_funct3, in_addr_lo)) begin
            err_new = 2'b10;
          end else begin
            latch_ld  = 1'b1;
            cnt_nxt   = 8'd0;
            state_nxt = WAIT_MEM;
          end
        end
      end
      WAIT_MEM: begin
        // rvalid is checked before the timeout so a last-cycle response still writes
        if (mem_rvalid) begin
          rd_addr_nxt = ld_rd;
          rd_data_nxt = extract(ld_f3, ld_lo, mem_rdata);
          we_nxt      = ld_we & (|ld_rd);
          state_nxt   = IDLE;
        end else if (cnt == TIMEOUT_CNT) begin
          err_new   = 2'b01;
          cnt_nxt   = 8'd0;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      cnt              <= 8'd0;
      ld_rd            <= 5'd0;
      ld_f3            <= 3'd0;
      ld_lo            <= 2'd0;
      ld_we            <= 1'b0;
      rd_addr          <= 5'd0;
      rd_data          <= 32'd0;
      reg_write_enable <= 1'b0;
      err_code         <= 2'b00;
    end else begin
      state            <= state_nxt;
      cnt              <= cnt_nxt;
      rd_addr          <= rd_addr_nxt;
      rd_data          <= rd_data_nxt;
      reg_write_enable <= we_nxt;
      if (latch_ld) begin
        ld_rd <= in_rd_addr;
        ld_f3 <= in_funct3;
        ld_lo <= in_addr_lo;
        ld_we <= in_reg_write;
      end
      if (err_clear)
        err_code <= 2'b00;
      else if (err_new != 2'b00)
        err_code <= err_new;
    end
  end

`ifdef WB_BYPASS_EN
  assign rs1_data = (reg_write_enable && rd_addr != 5'd0 && rd_addr == rs1_addr) ? rd_data : rs1_file_data;
  assign rs2_data = (reg_write_enable && rd_addr != 5'd0 && rd_addr == rs2_addr) ? rd_data : rs2_file_data;
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit with a cycle-level reference model and per-cycle compare.
module tb_writeback_unit;

  localparam int TO = 15;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  in_rd_addr = '0;
  logic        in_reg_write = 1'b0;
  logic [31:0] in_result = '0;
  logic        in_is_load = 1'b0;
  logic [2:0]  in_funct3 = '0;
  logic [1:0]  in_addr_lo = '0;
  logic [31:0] mem_rdata = '0;
  logic        mem_rvalid = 1'b0;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic        reg_write_enable;
  logic [1:0]  err_code;
  logic        err_clear = 1'b0;
`ifdef WB_BYPASS_EN
  logic [4:0]  rs1_addr = '0;
  logic [4:0]  rs2_addr = '0;
  logic [31:0] rs1_file_data = '0;
  logic [31:0] rs2_file_data = '0;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
`endif

  int tests = 0;
  int fails = 0;
  bit started = 1'b0;

  always #5 clk = ~clk;

  writeback_unit #(.MEM_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
`ifdef WB_BYPASS_EN
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_file_data(rs1_file_data), .rs2_file_data(rs2_file_data),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
`endif
    .in_valid(in_valid), .in_ready(in_ready), .in_rd_addr(in_rd_addr),
    .in_reg_write(in_reg_write), .in_result(in_result), .in_is_load(in_is_load),
    .in_funct3(in_funct3), .in_addr_lo(in_addr_lo), .mem_rdata(mem_rdata),
    .mem_rvalid(mem_rvalid), .rd_addr(rd_addr), .rd_data(rd_data),
    .reg_write_enable(reg_write_enable), .err_code(err_code), .err_clear(err_clear)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int ld_size(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      3'b010:         return 4;
      default:        return 0;
    endcase
  endfunction

  function automatic bit ld_legal(input logic [2:0] f3, input int off);
    int s = ld_size(f3);
    return (s == 1) || (s == 2 && off != 3) || (s == 4 && off == 0);
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input int off, input logic [31:0] w);
    int s = ld_size(f3);
    logic [31:0] sh, mask, v;
    if (s == 4) return w;
    sh   = (s == 2) ? (w >> ((off >= 2) ? 16 : 0)) : (w >> (8 * off));
    mask = (s == 2) ? 32'h0000_FFFF : 32'h0000_00FF;
    v    = sh & mask;
    if (!f3[2] && ((v & ~(mask >> 1)) != 0)) v = v | ~mask;
    return v;
  endfunction

  bit          m_busy = 0;
  int          m_waited = 0;
  logic [4:0]  p_rd = '0;
  logic [2:0]  p_f3 = '0;
  int          p_off = 0;
  bit          p_we = 0;
  bit          m_we = 0;
  logic [4:0]  m_addr = '0;
  logic [31:0] m_data = '0;
  logic [1:0]  m_err = '0;
  logic [1:0]  m_new_err;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy = 0; m_waited = 0; m_we = 0; m_addr = '0; m_data = '0; m_err = '0;
    end else begin
      m_new_err = 2'b00;
      m_we = 0;
      if (!m_busy) begin
        if (in_valid && !in_is_load) begin
          m_addr = in_rd_addr; m_data = in_result;
          m_we = in_reg_write && (in_rd_addr != 0);
        end else if (in_valid && !ld_legal(in_funct3, int'(in_addr_lo))) begin
          m_new_err = 2'b10;
        end else if (in_valid) begin
          m_busy = 1; m_waited = 0;
          p_rd = in_rd_addr; p_f3 = in_funct3; p_off = int'(in_addr_lo); p_we = in_reg_write;
        end
      end else if (mem_rvalid) begin
        m_addr = p_rd; m_data = ref_load(p_f3, p_off, mem_rdata);
        m_we = p_we && (p_rd != 0);
        m_busy = 0;
      end else begin
        m_waited++;
        // abort after the (TO+1)th silent waiting cycle
        if (m_waited > TO) begin m_new_err = 2'b01; m_busy = 0; end
      end
      if (err_clear) m_err = 2'b00;
      else if (m_new_err != 2'b00) m_err = m_new_err;
    end
  end

  always @(negedge clk) begin
    if (started && !reset) begin
      chk("in_ready", 32'(in_ready), 32'(!m_busy));
      chk("we", 32'(reg_write_enable), 32'(m_we));
      chk("err_code", 32'(err_code), 32'(m_err));
      if (m_we) begin
        chk("rd_addr", 32'(rd_addr), 32'(m_addr));
        chk("rd_data", rd_data, m_data);
      end
`ifdef WB_BYPASS_EN
      chk("rs1_data", rs1_data, (m_we && m_addr != 0 && m_addr == rs1_addr) ? m_data : rs1_file_data);
      chk("rs2_data", rs2_data, (m_we && m_addr != 0 && m_addr == rs2_addr) ? m_data : rs2_file_data);
`endif
    end
  end

  // ---------------- stimulus ----------------
  task automatic alu(input logic [4:0] rd, input logic [31:0] res, input bit we);
    in_valid = 1; in_is_load = 0; in_rd_addr = rd; in_result = res; in_reg_write = we;
    @(negedge clk);
    in_valid = 0;
  endtask

  task automatic issue_load(input logic [2:0] f3, input logic [1:0] off, input logic [4:0] rd);
    in_valid = 1; in_is_load = 1; in_funct3 = f3; in_addr_lo = off; in_rd_addr = rd; in_reg_write = 1;
    @(negedge clk);
    in_valid = 0; in_is_load = 0;
  endtask

  task automatic do_load(input string name, input logic [2:0] f3, input logic [1:0] off,
                         input logic [4:0] rd, input int delay, input logic [31:0] exp);
    issue_load(f3, off, rd);
    repeat (delay) @(negedge clk);
    mem_rdata = 32'h80FF7F01; mem_rvalid = 1;
    @(negedge clk);
    mem_rvalid = 0;
    chk({name, "_we"}, 32'(reg_write_enable), 32'd1);
    chk(name, rd_data, exp);
    @(negedge clk);
    chk({name, "_pulse"}, 32'(reg_write_enable), 32'd0);
  endtask

  task automatic pulse_reset();
    #2 reset = 1;
    #1;
    chk("arst_we", 32'(reg_write_enable), 32'd0);
    chk("arst_rd_addr", 32'(rd_addr), 32'd0);
    chk("arst_rd_data", rd_data, 32'd0);
    chk("arst_ready", 32'(in_ready), 32'd1);
    chk("arst_err", 32'(err_code), 32'd0);
    @(posedge clk);
    #2 reset = 0;
    @(negedge clk);
  endtask

  initial begin
    int n;
    reset = 1;
    #1;
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_we", 32'(reg_write_enable), 32'd0);
    chk("rst_err", 32'(err_code), 32'd0);
    repeat (2) @(posedge clk);
    #2 reset = 0;
    @(negedge clk);
    started = 1;

    alu(5'd5, 32'hDEADBEEF, 1);
    chk("alu_we", 32'(reg_write_enable), 32'd1);
    chk("alu_addr", 32'(rd_addr), 32'd5);
    chk("alu_data", rd_data, 32'hDEADBEEF);
    @(negedge clk);
    chk("alu_pulse", 32'(reg_write_enable), 32'd0);
    alu(5'd0, 32'h1111_2222, 1);
    chk("alu_x0_we", 32'(reg_write_enable), 32'd0);

    // back-to-back retires, including one with reg_write low
    alu(5'd1, 32'h0000_0001, 1);
    alu(5'd2, 32'h0000_0002, 0);
    alu(5'd3, 32'h0000_0003, 1);
    @(negedge clk);

    // asynchronous reset in the middle of a write-pulse cycle
    alu(5'd9, 32'hA5A5_5A5A, 1);
    pulse_reset();

    do_load("lb3",  3'b000, 2'd3, 5'd10, 0, 32'hFFFFFF80);
    do_load("lbu1", 3'b100, 2'd1, 5'd11, 2, 32'h0000007F);
    do_load("lh2",  3'b001, 2'd2, 5'd12, 1, 32'hFFFF80FF);
    do_load("lhu0", 3'b101, 2'd0, 5'd13, 3, 32'h00007F01);
    do_load("lw0",  3'b010, 2'd0, 5'd14, 0, 32'h80FF7F01);
    do_load("lh1",  3'b001, 2'd1, 5'd15, 0, 32'h00007F01);

    // misaligned LW, then clear
    issue_load(3'b010, 2'd2, 5'd4);
    chk("lw2_err", 32'(err_code), 32'd2);
    chk("lw2_we", 32'(reg_write_enable), 32'd0);
    chk("lw2_ready", 32'(in_ready), 32'd1);
    err_clear = 1; @(negedge clk); err_clear = 0;
    chk("clr_err", 32'(err_code), 32'd0);

    // timeout: exactly TO+1 silent cycles in WAIT_MEM
    issue_load(3'b000, 2'd0, 5'd6);
    n = 0;
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    chk("to_cycles", 32'(n), 32'd16);
    chk("to_err", 32'(err_code), 32'd1);
    chk("to_we", 32'(reg_write_enable), 32'd0);

    // new error overwrites, then clear wins over a same-cycle error
    issue_load(3'b110, 2'd0, 5'd6);
    chk("ovw_err", 32'(err_code), 32'd2);
    err_clear = 1;
    issue_load(3'b001, 2'd3, 5'd6);
    err_clear = 0;
    chk("clr_prio_err", 32'(err_code), 32'd0);

    // rvalid on the last allowed cycle still writes
    do_load("late", 3'b010, 2'd0, 5'd8, TO, 32'h80FF7F01);
    chk("late_err", 32'(err_code), 32'd0);

    // load to x0 produces no write
    issue_load(3'b010, 2'd0, 5'd0);
    mem_rvalid = 1; @(negedge clk); mem_rvalid = 0;
    chk("ld_x0_we", 32'(reg_write_enable), 32'd0);

    // stray rvalid in IDLE
    mem_rvalid = 1; @(negedge clk); mem_rvalid = 0;
    chk("stray_we", 32'(reg_write_enable), 32'd0);

    // reset while waiting for memory; later rvalid ignored
    issue_load(3'b010, 2'd0, 5'd20);
    pulse_reset();
    mem_rvalid = 1; @(negedge clk); mem_rvalid = 0;
    chk("rst_wait_we", 32'(reg_write_enable), 32'd0);
    @(negedge clk);

`ifdef WB_BYPASS_EN
    rs1_addr = 5'd7; rs1_file_data = 32'h0; rs2_addr = 5'd0; rs2_file_data = 32'hCAFE_F00D;
    alu(5'd7, 32'h12345678, 1);
    chk("byp_rs1", rs1_data, 32'h12345678);
    chk("byp_rs2", rs2_data, 32'hCAFE_F00D);
    @(negedge clk);
    chk("byp_rs1_after", rs1_data, 32'h0);
`endif

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/writeback_unit.md
# writeback_unit

Writeback stage sitting directly upstream of the register file. It accepts completed instructions from execute/memory over a valid/ready handshake and waits for load data where needed. It performs RV32I load byte/halfword extraction and sign/zero extension, then drives the register file's write port (rd_addr, rd_data, reg_write_enable) as a registered one-cycle pulse. Optionally, it bypasses the write-in-flight value to same-cycle operand reads.

## Interface
- MEM_TIMEOUT, 15: maximum cycles spent in WAIT_MEM before abort; legal range 1..255.
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- in_valid  in  1  upstream has an instruction to retire
- in_ready  out  1  block can accept; high in IDLE only
- in_rd_addr  in  5  destination register
- in_reg_write  in  1  instruction writes rd
- in_result  in  32  ALU/PC+4 result (ignored for loads)
- in_is_load  in  1  result comes from memory
- in_funct3  in  3  load type
- in_addr_lo  in  2  byte offset of load address
- mem_rdata  in  32  aligned word from data memory
- mem_rvalid  in  1  mem_rdata valid this cycle
- rd_addr  out  5  to register file
- rd_data  out  32  to register file
- reg_write_enable  out  1  to register file; single-cycle pulse
- err_code  out  2  sticky: 00 none, 01 load timeout, 10 misaligned/illegal load
- err_clear  in  1  clears err_code
- rs1_addr, rs2_addr  in  5  operand read addresses (WB_BYPASS_EN only)
- rs1_file_data, rs2_file_data  in  32  register file read data (WB_BYPASS_EN only)
- rs1_data, rs2_data  out  32  bypassed operands (WB_BYPASS_EN only)

## Operation
- States: IDLE, WAIT_MEM. Reset -> IDLE; all outputs 0, err_code=00, timeout counter 0.
- IDLE, in_valid & !in_is_load: next cycle rd_addr=in_rd_addr, rd_data=in_result, reg_write_enable=in_reg_write & (in_rd_addr!=0). Stay IDLE.
- IDLE, in_valid & in_is_load: latch rd/funct3/addr_lo/reg_write; -> WAIT_MEM; counter cleared.
- Misalignment/illegality checked at acceptance: LH/LHU with addr_lo==3, LW with addr_lo!=0, funct3 in {011,110,111} -> err_code=10, no write, stay IDLE.
- WAIT_MEM: counter increments each cycle without mem_rvalid. On mem_rvalid: extract, write per rule above next cycle, -> IDLE. If counter reaches MEM_TIMEOUT without rvalid: err_code=01, no write, -> IDLE.
- Extraction: byte = mem_rdata[8*addr_lo +: 8]; half = mem_rdata[16*addr_lo[1] +: 16]. LB/LH sign-extend to 32, LBU/LHU zero-extend, LW passes word.
- mem_rvalid in IDLE ignored. reg_write_enable low in every cycle not listed above.
- err_code: new error overwrites; err_clear has priority over a same-cycle new error.
- Reset mid-WAIT_MEM: -> IDLE, no write, a later stray rvalid is ignored.

## Timing
- ALU retire: accept at edge N -> reg_write_enable high during cycle N+1 only.
- Load: mem_rvalid sampled at edge M -> reg_write_enable high during cycle M+1.
- Minimum load latency: accept N, rvalid at N+1, write in N+2.
- Timeout: rvalid and counter==MEM_TIMEOUT in same cycle -> rvalid wins, write occurs, no error.
- in_ready combinational from state only (no in_valid dependence).
- Throughput: one non-load per cycle; loads block acceptance until WAIT_MEM exits.

## Configuration
- WB_BYPASS_EN defined: rs*_addr/rs*_file_data/rs*_data ports exist; rsX_data = rd_data when reg_write_enable & rd_addr!=0 & rd_addr==rsX_addr, else rsX_file_data (combinational).
- Undefined: bypass ports and logic absent; consumers read the register file directly and see the written value one cycle later.

## Test plan
- Reset asserted mid-cycle -> all outputs 0, in_ready=1, err_code=00 immediately (asynchronous).
- ALU: in_rd_addr=5, in_result=0xDEADBEEF, reg_write=1 -> next cycle rd_addr=5, rd_data=0xDEADBEEF, we=1 for one cycle; same with rd=0 -> we=0.
- Loads from mem_rdata=0x80FF7F01: LB off 3 -> 0xFFFFFF80; LBU off 1 -> 0x0000007F; LH off 2 -> 0xFFFF80FF; LHU off 0 -> 0x00007F01; LW off 0 -> 0x80FF7F01.
- LW off 2 -> err_code=10, no write; err_clear -> 00. Load with no rvalid for MEM_TIMEOUT cycles -> err_code=01, in_ready returns 1, no write.
- Reset during WAIT_MEM, then rvalid -> no write.
- WB_BYPASS_EN: write rd=7 value 0x12345678 while rs1_addr=7, rs1_file_data=0 -> rs1_data=0x12345678; rs2_addr=0 -> rs2_file_data passed.
